// File: rtl/lfsr_reconfig.sv
// ---------------------------------------------------------------------------
// lfsr_reconfig
//
// Runtime-reconfigurable LFSR pseudo-random generator. The tap mask, seed and
// topology (Fibonacci or Galois) are loaded while idle. Each burst produces
// burst_len values under a start/busy/done handshake, and enable gates every
// advance. If the next state would be all-zero, the generator reloads the seed
// instead and pulses lockup, so it can never stick at zero.
//
// Parameters
//   WIDTH         LFSR width in bits (3..32)
//   CNT_W         burst counter width; longest burst is 2**CNT_W-1 values
//   DEFAULT_TAPS  tap mask after reset
//   DEFAULT_SEED  seed after reset; must be nonzero
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high; restores power-on state
//   enable     in   allows an advance while a burst is running
//   cfg_wr     in   loads cfg_mode/cfg_taps/cfg_seed (honoured only when idle)
//   cfg_mode   in   0 = Fibonacci, 1 = Galois
//   cfg_taps   in   tap mask
//   cfg_seed   in   seed; zero is replaced by DEFAULT_SEED
//   start      in   begins a burst (honoured only when idle, burst_len != 0)
//   abort      in   ends a running burst early, without done
//   burst_len  in   number of advances in the burst
//   lfsr_out   out  current LFSR state
//   out_valid  out  lfsr_out advanced at the last edge
//   busy       out  burst in progress
//   done       out  one-cycle pulse alongside the final value of a burst
//   lockup     out  one-cycle pulse: the zero state was replaced by the seed
// ---------------------------------------------------------------------------
module lfsr_reconfig #(
   parameter int               WIDTH        = 3,
   parameter int               CNT_W        = 8,
   parameter logic [WIDTH-1:0] DEFAULT_TAPS = 3'b101,
   parameter logic [WIDTH-1:0] DEFAULT_SEED = 3'b001
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             cfg_wr,
   input  logic             cfg_mode,
   input  logic [WIDTH-1:0] cfg_taps,
   input  logic [WIDTH-1:0] cfg_seed,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] burst_len,
   output logic [WIDTH-1:0] lfsr_out,
   output logic             out_valid,
   output logic             busy,
   output logic             done,
   output logic             lockup
);

   typedef enum logic {
      IDLE,
      RUN
   } stateT;

   stateT            r_state;
   stateT            w_stateNext;
   logic [WIDTH-1:0] r_taps;
   logic [WIDTH-1:0] w_tapsNext;
   logic [WIDTH-1:0] r_seed;
   logic [WIDTH-1:0] w_seedNext;
   logic             r_mode;
   logic             w_modeNext;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cntNext;
   logic [WIDTH-1:0] w_lfsrNext;
   logic             w_validNext;
   logic             w_busyNext;
   logic             w_doneNext;
   logic             w_lockupNext;
   logic [WIDTH-1:0] w_advance;
   logic [WIDTH-1:0] w_cfgSeed;

   // Candidate next LFSR value for the selected topology. Fibonacci feeds the
   // parity of the tapped bits into the LSB. Galois shifts left and XORs the
   // tap mask in whenever the MSB falls off the top.
   always_comb begin
      w_advance = '0;
      if (r_mode == 1'b0) begin
         w_advance = {lfsr_out[WIDTH-2:0], ^(lfsr_out & r_taps)};
      end else begin
         w_advance = {lfsr_out[WIDTH-2:0], 1'b0} ^ (lfsr_out[WIDTH-1] ? r_taps : '0);
      end
   end

   // A zero seed would lock the generator at zero, so it is replaced by the
   // default at load time.
   always_comb begin
      w_cfgSeed = (cfg_seed != '0) ? cfg_seed : DEFAULT_SEED;
   end

   // Next-state and next-output logic. Everything holds by default. The three
   // pulses (out_valid, done, lockup) default low, so each lasts exactly one
   // cycle unless it is triggered again.
   always_comb begin
      w_stateNext  = r_state;
      w_tapsNext   = r_taps;
      w_seedNext   = r_seed;
      w_modeNext   = r_mode;
      w_cntNext    = r_cnt;
      w_lfsrNext   = lfsr_out;
      w_validNext  = 1'b0;
      w_busyNext   = busy;
      w_doneNext   = 1'b0;
      w_lockupNext = 1'b0;

      case (r_state)
         IDLE: begin
            if (cfg_wr) begin
               w_tapsNext = cfg_taps;
               w_modeNext = cfg_mode;
               w_seedNext = w_cfgSeed;
               w_lfsrNext = w_cfgSeed;
            end else if (start && (burst_len != '0)) begin
               w_cntNext   = burst_len;
               w_busyNext  = 1'b1;
               w_stateNext = RUN;
            end
         end
         RUN: begin
            if (abort) begin
               w_busyNext  = 1'b0;
               w_stateNext = IDLE;
            end else if (enable) begin
               if (w_advance == '0) begin
                  w_lfsrNext   = r_seed;
                  w_lockupNext = 1'b1;
               end else begin
                  w_lfsrNext = w_advance;
               end
               w_validNext = 1'b1;
               w_cntNext   = r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) begin
                  w_busyNext  = 1'b0;
                  w_doneNext  = 1'b1;
                  w_stateNext = IDLE;
               end
            end
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase
   end

   // State and output registers. Reset discards any loaded configuration
   // along with any burst in progress.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_taps    <= DEFAULT_TAPS;
         r_seed    <= DEFAULT_SEED;
         r_mode    <= 1'b0;
         r_cnt     <= '0;
         lfsr_out  <= DEFAULT_SEED;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         lockup    <= 1'b0;
      end else begin
         r_state   <= w_stateNext;
         r_taps    <= w_tapsNext;
         r_seed    <= w_seedNext;
         r_mode    <= w_modeNext;
         r_cnt     <= w_cntNext;
         lfsr_out  <= w_lfsrNext;
         out_valid <= w_validNext;
         busy      <= w_busyNext;
         done      <= w_doneNext;
         lockup    <= w_lockupNext;
      end
   end

endmodule
